// File: rtl/cdc_bus_tx_arbiter_if.sv
// rtl/cdc_bus_tx_arbiter_if.sv - requester/synchronizer bundle for the cdc bus tx arbiter
//
// Purpose: groups the requester handshake and the synchronizer-facing bus
// of cdc_bus_tx_arbiter into one interface.
// Signals:
//   en          arbitration enable (gates new grants only)
//   req_valid   per-requester request, NUM_REQ bits
//   req_data    packed words, requester i at [i*BUS_WIDTH +: BUS_WIDTH]
//   req_ready   one-hot accept from the arbiter
//   unsync_bus  registered word to the synchronizer
//   bus_enable  registered enable to the synchronizer
//   grant_id    index of the last accepted requester
//   busy        transfer in progress (HOLD or GAP)
//   xfer_done   one-cycle pulse on the last GAP cycle
// Modports: master = arbiter side, slave = requester/observer side.
interface cdc_bus_tx_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int BUS_WIDTH = 8
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic                         en;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*BUS_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ready;
  logic [BUS_WIDTH-1:0]         unsync_bus;
  logic                         bus_enable;
  logic [ID_W-1:0]              grant_id;
  logic                         busy;
  logic                         xfer_done;

  modport master (
    input  en, req_valid, req_data,
    output req_ready, unsync_bus, bus_enable, grant_id, busy, xfer_done
  );

  modport slave (
    output en, req_valid, req_data,
    input  req_ready, unsync_bus, bus_enable, grant_id, busy, xfer_done
  );
endinterface

// File: rtl/cdc_bus_tx_arbiter.sv
// rtl/cdc_bus_tx_arbiter.sv - round-robin scheduler driving a multi-stage bus synchronizer
//
// Purpose: shares one unsync_bus/bus_enable pair between NUM_REQ requesters.
// One word is accepted at a time by rotating priority, held with bus_enable
// high for HOLD_CYCLES cycles, then bus_enable is held low for GAP_CYCLES
// cycles so every enable edge is seen by the destination clock.
// Ports:
//   CLK  source-domain clock
//   RST  synchronous active-high reset
//   bus  cdc_bus_tx_arbiter_if.master (requester handshake + synchronizer bus)
module cdc_bus_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int BUS_WIDTH   = 8,
  parameter int HOLD_CYCLES = 6,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  cdc_bus_tx_arbiter_if.master bus
);
  localparam int ID_W    = $clog2(NUM_REQ);
  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ID_W-1:0]      last_q, last_d;
  logic [ID_W-1:0]      gid_q, gid_d;
  logic [BUS_WIDTH-1:0] word_q, word_d;
  logic                 ben_q, ben_d;

  logic [NUM_REQ-1:0]   pick;
  logic [ID_W-1:0]      sel_idx;
  logic [ID_W-1:0]      scan_idx;
  logic                 found;
  logic [NUM_REQ-1:0]   ready;
  logic                 accept;

  // Rotating-priority search: start just after the last winner and wrap.
  always_comb begin
    pick     = '0;
    sel_idx  = '0;
    scan_idx = '0;
    found    = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = ID_W'((int'(last_q) + k) % NUM_REQ);
      if (!found && bus.req_valid[scan_idx]) begin
        pick[scan_idx] = 1'b1;
        sel_idx        = scan_idx;
        found          = 1'b1;
      end
    end
  end

  // Grants only from IDLE with en high; reset forces ready low combinationally.
  assign ready  = (RST || !bus.en || state_q != IDLE) ? '0 : pick;
  assign accept = |ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gid_d   = gid_q;
    word_d  = word_q;
    ben_d   = ben_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          word_d  = bus.req_data[sel_idx*BUS_WIDTH +: BUS_WIDTH];
          ben_d   = 1'b1;
          gid_d   = sel_idx;
          last_d  = sel_idx;
          cnt_d   = CNT_W'(HOLD_CYCLES - 1);
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          ben_d   = 1'b0;
          cnt_d   = CNT_W'(GAP_CYCLES - 1);
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        // The word stays on the bus; only the enable drops.
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= ID_W'(NUM_REQ - 1);
      gid_q   <= '0;
      word_q  <= '0;
      ben_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      word_q  <= word_d;
      ben_q   <= ben_d;
    end
  end

  assign bus.req_ready  = ready;
  assign bus.unsync_bus = word_q;
  assign bus.bus_enable = ben_q;
  assign bus.grant_id   = gid_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.xfer_done  = (state_q == GAP) && (cnt_q == '0);
endmodule

// File: tb/tb_cdc_bus_tx_arbiter.sv
// tb/tb_cdc_bus_tx_arbiter.sv - self-checking bench for cdc_bus_tx_arbiter
module tb_cdc_bus_tx_arbiter;
  localparam int N    = 4;
  localparam int W    = 8;
  localparam int H    = 6;
  localparam int G    = 4;
  localparam int ID_W = 2;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  cdc_bus_tx_arbiter_if #(.NUM_REQ(N), .BUS_WIDTH(W)) bif ();

  cdc_bus_tx_arbiter #(
    .NUM_REQ(N), .BUS_WIDTH(W), .HOLD_CYCLES(H), .GAP_CYCLES(G)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bif.master)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: time since the accepting edge, not a state machine.
  logic         m_active;
  int           m_t;
  logic [W-1:0] m_word;
  int           m_gid;
  int           m_last;
  int           grants[$];
  int           run_len;
  int           max_run;

  typedef struct {
    logic            en;
    logic [N-1:0]    valid;
    logic [N-1:0]    ready;
    logic            be;
    logic [W-1:0]    bus;
    logic [ID_W-1:0] gid;
    logic            busy;
    logic            done;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] pick(input logic [N-1:0] v, input int last);
    logic [N-1:0] r;
    r = '0;
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (v[i]) begin
        r[i] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  function automatic logic [N-1:0] m_exp_ready();
    if (RST || !bif.en || m_active) return '0;
    return pick(bif.req_valid, m_last);
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_t      = 0;
    m_word   = '0;
    m_gid    = 0;
    m_last   = N - 1;
  endtask

  task automatic model_update(input logic rst, input logic [N-1:0] r, input logic [N*W-1:0] d);
    if (rst) begin
      model_reset();
    end else if (r != '0) begin
      for (int i = 0; i < N; i++) begin
        if (r[i]) begin
          m_active = 1'b1;
          m_t      = 1;
          m_word   = d[i*W +: W];
          m_gid    = i;
          m_last   = i;
          grants.push_back(i);
        end
      end
    end else if (m_active) begin
      m_t++;
      if (m_t > H + G) m_active = 1'b0;
    end
  endtask

  task automatic drive(input logic rst, input logic en, input logic [N-1:0] v, input logic [N*W-1:0] d);
    RST           = rst;
    bif.en        = en;
    bif.req_valid = v;
    bif.req_data  = d;
  endtask

  // Called at the negedge: record expectation, cross the edge, update the model.
  task automatic advance();
    logic [N-1:0] r;
    r = m_exp_ready();
    if (bif.bus_enable === 1'b1) run_len++;
    else run_len = 0;
    if (run_len > max_run) max_run = run_len;
    @(posedge CLK);
    model_update(RST, r, bif.req_data);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".ready"}, 32'(bif.req_ready), 32'(m_exp_ready()));
    chk({tag, ".bus_enable"}, 32'(bif.bus_enable), 32'(m_active && m_t <= H));
    chk({tag, ".unsync_bus"}, 32'(bif.unsync_bus), 32'(m_word));
    chk({tag, ".grant_id"}, 32'(bif.grant_id), 32'(m_gid));
    chk({tag, ".busy"}, 32'(bif.busy), 32'(m_active));
    chk({tag, ".xfer_done"}, 32'(bif.xfer_done), 32'(m_active && m_t == H + G));
  endtask

  task automatic cycle(input logic rst, input logic en, input logic [N-1:0] v,
                       input logic [N*W-1:0] d, input string tag);
    drive(rst, en, v, d);
    @(negedge CLK);
    check_model(tag);
    advance();
  endtask

  initial begin
    int n0;
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    run_len   = 0;
    max_run   = 0;
    model_reset();
    drive(1'b1, 1'b1, 4'b0001, 32'h0000_00A5);
    repeat (2) @(posedge CLK);
    #1;
    // Reset state, with a pending request that must not be readied.
    cycle(1'b1, 1'b1, 4'b0001, 32'h0000_00A5, "reset");

    // Single transfer from requester 0: exact cycle-by-cycle expectations.
    tbl[0] = '{en: 1'b1, valid: 4'b0001, ready: 4'b0001, be: 1'b0, bus: 8'h00,
               gid: 2'd0, busy: 1'b0, done: 1'b0};
    for (int i = 1; i < 12; i++) begin
      tbl[i] = '{en: 1'b1, valid: 4'b0000, ready: 4'b0000, be: (i <= 6), bus: 8'hA5,
                 gid: 2'd0, busy: (i <= 10), done: (i == 10)};
    end
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, tbl[i].en, tbl[i].valid, 32'h0000_00A5);
      @(negedge CLK);
      chk($sformatf("tbl%0d.ready", i), 32'(bif.req_ready), 32'(tbl[i].ready));
      chk($sformatf("tbl%0d.bus_enable", i), 32'(bif.bus_enable), 32'(tbl[i].be));
      chk($sformatf("tbl%0d.unsync_bus", i), 32'(bif.unsync_bus), 32'(tbl[i].bus));
      chk($sformatf("tbl%0d.grant_id", i), 32'(bif.grant_id), 32'(tbl[i].gid));
      chk($sformatf("tbl%0d.busy", i), 32'(bif.busy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d.xfer_done", i), 32'(bif.xfer_done), 32'(tbl[i].done));
      advance();
    end

    // Wrap-around priority: make requester 1 the last winner, then offer 3 and 0.
    cycle(1'b0, 1'b1, 4'b0010, 32'h0000_5500, "wrap_pre");
    repeat (11) cycle(1'b0, 1'b1, 4'b0000, 32'h0, "wrap_wait");
    cycle(1'b0, 1'b1, 4'b1001, 32'h7700_0066, "wrap");
    chk("wrap_grant", 32'(grants[$]), 32'd3);
    repeat (11) cycle(1'b0, 1'b1, 4'b0000, 32'h0, "wrap_drain");

    // Fairness with all requesters continuously valid, from a fresh reset.
    cycle(1'b1, 1'b1, 4'b0000, 32'h0, "rr_reset");
    grants.delete();
    max_run = 0;
    repeat (50) cycle(1'b0, 1'b1, 4'b1111, 32'h4332_2110, "rr");
    chk("rr_count", 32'(grants.size()), 32'd5);
    for (int i = 0; i < 5 && i < grants.size(); i++)
      chk($sformatf("rr_order%0d", i), 32'(grants[i]), 32'(exp_order[i]));
    chk("rr_max_enable_run", 32'(max_run), 32'(H));
    repeat (12) cycle(1'b0, 1'b1, 4'b0000, 32'h0, "rr_drain");

    // en low blocks grants; raising it grants requester 2 in the same cycle.
    n0 = grants.size();
    repeat (15) cycle(1'b0, 1'b0, 4'b0100, 32'h00CC_0000, "en_off");
    chk("en_off_no_grant", 32'(grants.size()), 32'(n0));
    cycle(1'b0, 1'b1, 4'b0100, 32'h00CC_0000, "en_on");
    chk("en_on_count", 32'(grants.size()), 32'(n0 + 1));
    chk("en_on_grant", 32'(grants[$]), 32'd2);

    // Reset during the 3rd HOLD cycle; first post-reset grant goes to 0.
    repeat (2) cycle(1'b0, 1'b1, 4'b0000, 32'h0, "hold");
    cycle(1'b1, 1'b1, 4'b0000, 32'h0, "hold_rst");
    n0 = grants.size();
    cycle(1'b0, 1'b1, 4'b1111, 32'h4433_2211, "post_rst");
    chk("post_rst_grant", 32'(grants[$]), 32'd0);

    // Requester 1 withdraws during requester 0's HOLD and is never granted.
    repeat (2) cycle(1'b0, 1'b1, 4'b0010, 32'h0000_9900, "withdraw");
    repeat (14) cycle(1'b0, 1'b1, 4'b0000, 32'h0, "withdraw_idle");
    chk("withdraw_no_grant", 32'(grants.size()), 32'(n0 + 1));

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(0, 63) == 0, $urandom_range(0, 7) != 0,
            4'($urandom), $urandom, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
